// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: one DM access per cycle shared between the core (ps) and host (hp).
// Define DM_ARB_RR_EN for strict round-robin; otherwise fixed ps priority with hp aging.
module dm_port_arbiter #(
    parameter int unsigned DMA_SIZE = 17,
    parameter int unsigned DMD_SIZE = 16,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ps_req,
    input  logic                ps_wrb,
    input  logic [DMA_SIZE-1:0] ps_add,
    input  logic [DMD_SIZE-1:0] ps_wdata,
    output logic                ps_gnt,
    output logic                ps_rvalid,
    output logic [DMD_SIZE-1:0] ps_rdata,

    input  logic                hp_req,
    input  logic                hp_wrb,
    input  logic [DMA_SIZE-1:0] hp_add,
    input  logic [DMD_SIZE-1:0] hp_wdata,
    output logic                hp_gnt,
    output logic                hp_rvalid,
    output logic [DMD_SIZE-1:0] hp_rdata,

    output logic                mem_cslt,
    output logic                mem_wrb,
    output logic [DMA_SIZE-1:0] mem_add,
    output logic [DMD_SIZE-1:0] mem_wdata,
    input  logic [DMD_SIZE-1:0] mem_rdata,

    output logic                hp_starved
);

    localparam logic OwnPs = 1'b0;
    localparam logic OwnHp = 1'b1;

    logic                ps_win;
    logic                hp_win;
    logic                contended;

    logic                mem_cslt_q, mem_cslt_d;
    logic                mem_wrb_q, mem_wrb_d;
    logic [DMA_SIZE-1:0] mem_add_q, mem_add_d;
    logic [DMD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                own_q, own_d;

    logic [RD_LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0]   tag_own_q, tag_own_d;
    logic                ret_vld;
    logic                ret_own;

    logic                ps_rvalid_q, ps_rvalid_d;
    logic                hp_rvalid_q, hp_rvalid_d;
    logic [DMD_SIZE-1:0] ps_rdata_q, ps_rdata_d;
    logic [DMD_SIZE-1:0] hp_rdata_q, hp_rdata_d;

`ifdef DM_ARB_RR_EN
    logic                rr_hp_q, rr_hp_d;
`else
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                hp_starved_q, hp_starved_d;
`endif

    assign contended = ps_req & hp_req;

    // Grants are suppressed while reset is sampled low so nothing is accepted during reset.
    always_comb begin
        ps_win = 1'b0;
        hp_win = 1'b0;
        if (reset) begin
            if (contended) begin
`ifdef DM_ARB_RR_EN
                hp_win = rr_hp_q;
`else
                hp_win = hp_starved_q;
`endif
                ps_win = ~hp_win;
            end else begin
                ps_win = ps_req;
                hp_win = hp_req;
            end
        end
    end

    assign ps_gnt = ps_win;
    assign hp_gnt = hp_win;

`ifdef DM_ARB_RR_EN
    // Pointer names the side that gets priority on the next contested cycle.
    always_comb begin
        rr_hp_d = rr_hp_q;
        if (reset && contended) begin
            rr_hp_d = ps_win;
        end
    end

    assign hp_starved = 1'b0;
`else
    always_comb begin
        wait_cnt_d = '0;
        if (hp_req && !hp_win) begin
            wait_cnt_d = (wait_cnt_q >= MaxWait) ? MaxWait : wait_cnt_q + 4'd1;
        end
        hp_starved_d = (wait_cnt_d == MaxWait);
    end

    assign hp_starved = hp_starved_q;
`endif

    // Issue stage: the winner's command is registered onto the DM port; mem_* hold when idle.
    always_comb begin
        mem_cslt_d  = ps_win | hp_win;
        mem_wrb_d   = mem_wrb_q;
        mem_add_d   = mem_add_q;
        mem_wdata_d = mem_wdata_q;
        own_d       = own_q;
        if (ps_win) begin
            mem_wrb_d   = ps_wrb;
            mem_add_d   = ps_add;
            mem_wdata_d = ps_wdata;
            own_d       = OwnPs;
        end else if (hp_win) begin
            mem_wrb_d   = hp_wrb;
            mem_add_d   = hp_add;
            mem_wdata_d = hp_wdata;
            own_d       = OwnHp;
        end
    end

    // Read tags travel alongside the DM latency; the tail lines up with valid mem_rdata.
    always_comb begin
        tag_vld_d    = tag_vld_q << 1;
        tag_own_d    = tag_own_q << 1;
        tag_vld_d[0] = mem_cslt_q & ~mem_wrb_q;
        tag_own_d[0] = own_q;
    end

    assign ret_vld = tag_vld_q[RD_LAT-1];
    assign ret_own = tag_own_q[RD_LAT-1];

    always_comb begin
        ps_rvalid_d = ret_vld & (ret_own == OwnPs);
        hp_rvalid_d = ret_vld & (ret_own == OwnHp);
        ps_rdata_d  = ps_rdata_q;
        hp_rdata_d  = hp_rdata_q;
        if (ps_rvalid_d) begin
            ps_rdata_d = mem_rdata;
        end
        if (hp_rvalid_d) begin
            hp_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_cslt_q   <= 1'b0;
            mem_wrb_q    <= 1'b0;
            mem_add_q    <= '0;
            mem_wdata_q  <= '0;
            own_q        <= OwnPs;
            tag_vld_q    <= '0;
            tag_own_q    <= '0;
            ps_rvalid_q  <= 1'b0;
            hp_rvalid_q  <= 1'b0;
            ps_rdata_q   <= '0;
            hp_rdata_q   <= '0;
`ifdef DM_ARB_RR_EN
            rr_hp_q      <= 1'b0;
`else
            wait_cnt_q   <= '0;
            hp_starved_q <= 1'b0;
`endif
        end else begin
            mem_cslt_q   <= mem_cslt_d;
            mem_wrb_q    <= mem_wrb_d;
            mem_add_q    <= mem_add_d;
            mem_wdata_q  <= mem_wdata_d;
            own_q        <= own_d;
            tag_vld_q    <= tag_vld_d;
            tag_own_q    <= tag_own_d;
            ps_rvalid_q  <= ps_rvalid_d;
            hp_rvalid_q  <= hp_rvalid_d;
            ps_rdata_q   <= ps_rdata_d;
            hp_rdata_q   <= hp_rdata_d;
`ifdef DM_ARB_RR_EN
            rr_hp_q      <= rr_hp_d;
`else
            wait_cnt_q   <= wait_cnt_d;
            hp_starved_q <= hp_starved_d;
`endif
        end
    end

    assign mem_cslt  = mem_cslt_q;
    assign mem_wrb   = mem_wrb_q;
    assign mem_add   = mem_add_q;
    assign mem_wdata = mem_wdata_q;
    assign ps_rvalid = ps_rvalid_q;
    assign hp_rvalid = hp_rvalid_q;
    assign ps_rdata  = ps_rdata_q;
    assign hp_rdata  = hp_rdata_q;

endmodule
